// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate-format instruction encoder: opcodes, field positions, FSM states.
// Optional feature macro: IMM_ENCODER_EXPAND_EN (out-of-range op-1000 requests become an upper+imm pair).
package imm_pkg;

  localparam logic [3:0] OP_UPPER  = 4'b0101;
  localparam logic [3:0] OP_BRANCH = 4'b0110;
  localparam logic [3:0] OP_IMM0   = 4'b1000;
  localparam logic [3:0] OP_IMM1   = 4'b1001;
  localparam logic [3:0] OP_IMM2   = 4'b1010;
  localparam logic [3:0] OP_IMM3   = 4'b1011;

  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 4;
  localparam int OP_MSB  = 3;
  localparam int OP_LSB  = 0;

`ifdef IMM_ENCODER_EXPAND_EN
  localparam bit EXPAND_EN = 1'b1;
`else
  localparam bit EXPAND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT1 = 2'd1,
    ST_EMIT2 = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  function automatic logic [15:0] pack_inst(input logic [7:0] imm8,
                                            input logic [3:0] rd,
                                            input logic [3:0] op);
    logic [15:0] w_word;
    w_word                 = '0;
    w_word[IMM_MSB:IMM_LSB] = imm8;
    w_word[RD_MSB:RD_LSB]   = rd;
    w_word[OP_MSB:OP_LSB]   = op;
    return w_word;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request and instruction-stream handshake bundle for imm_encoder.
// slave = encoder side, master = requester/consumer side.
interface imm_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [3:0]  req_rd;
  logic [15:0] req_value;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic        err;

  modport slave (
    input  req_valid, req_op, req_rd, req_value, inst_ready,
    output req_ready, inst_valid, inst, err
  );

  modport master (
    output req_valid, req_op, req_rd, req_value, inst_ready,
    input  req_ready, inst_valid, inst, err
  );
endinterface

// File: rtl/imm_encoder_range_check.sv
// Combinational immediate classifier: decides whether a value fits the opcode's
// 8-bit immediate rule and produces the field contents for the direct and expanded forms.
module imm_range_check
  import imm_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [15:0] i_value,
  output logic        o_fits,
  output logic        o_needs_expand,
  output logic [7:0]  o_imm8,
  output logic [7:0]  o_hi8
);

  logic w_imm_sx;
  logic w_br_sx;

  assign w_imm_sx = (&i_value[15:7]) | ~(|i_value[15:7]);
  assign w_br_sx  = (&i_value[15:8]) | ~(|i_value[15:8]);

  always_comb begin
    o_fits = 1'b0;
    o_imm8 = i_value[7:0];
    unique case (i_op)
      OP_IMM0, OP_IMM1, OP_IMM2, OP_IMM3: o_fits = w_imm_sx;
      OP_UPPER: begin
        o_fits = (i_value[7:0] == 8'h00);
        o_imm8 = i_value[15:8];
      end
      OP_BRANCH: begin
        o_fits = w_br_sx & ~i_value[0];
        o_imm8 = i_value[8:1];
      end
      default: o_fits = 1'b0;
    endcase
  end

  // Upper half is rounded up when the low byte will sign-extend negative.
  assign o_needs_expand = (i_op == OP_IMM0) && !w_imm_sx;
  assign o_hi8          = i_value[15:8] + {7'd0, i_value[7]};

endmodule

// File: rtl/imm_encoder.sv
// Immediate-format instruction encoder: accepts one request, emits one word (or an
// upper+imm pair when IMM_ENCODER_EXPAND_EN is defined) or a one-cycle err pulse.
module imm_encoder
  import imm_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  imm_encoder_if.slave bus
);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_inst;
  logic        w_req_ready;
  logic        w_inst_valid;
  logic        w_err;
  logic        w_fits;
  logic        w_needs_expand;
  logic [7:0]  w_imm8;
  logic [7:0]  w_hi8;
  logic        w_go_expand;
  logic        w_encodable;
  logic        w_accept;
  logic        w_take_first;

  imm_range_check u_range_check (
    .i_op           (bus.req_op),
    .i_value        (bus.req_value),
    .o_fits         (w_fits),
    .o_needs_expand (w_needs_expand),
    .o_imm8         (w_imm8),
    .o_hi8          (w_hi8)
  );

  assign w_go_expand  = EXPAND_EN && w_needs_expand;
  assign w_encodable  = w_fits || w_go_expand;
  assign w_accept     = w_req_ready && bus.req_valid;
  assign w_take_first = (r_state == ST_EMIT1) && bus.inst_ready;

`ifdef IMM_ENCODER_EXPAND_EN
  logic [15:0] r_pend;
  logic        r_has_pend;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pend     <= '0;
      r_has_pend <= 1'b0;
    end else if (w_accept && w_encodable) begin
      r_pend     <= pack_inst(bus.req_value[7:0], bus.req_rd, OP_IMM0);
      r_has_pend <= w_go_expand;
    end else if (w_take_first) begin
      r_has_pend <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) w_state_next = w_encodable ? ST_EMIT1 : ST_ERR;
      end
      ST_EMIT1: begin
        if (bus.inst_ready) begin
`ifdef IMM_ENCODER_EXPAND_EN
          w_state_next = r_has_pend ? ST_EMIT2 : ST_IDLE;
`else
          w_state_next = ST_IDLE;
`endif
        end
      end
      ST_EMIT2: if (bus.inst_ready) w_state_next = ST_IDLE;
      ST_ERR:   w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // req_ready is also held low while reset is asserted.
  always_comb begin
    w_req_ready  = 1'b0;
    w_inst_valid = 1'b0;
    w_err        = 1'b0;
    unique case (r_state)
      ST_IDLE:  w_req_ready  = reset;
      ST_EMIT1: w_inst_valid = 1'b1;
      ST_EMIT2: w_inst_valid = 1'b1;
      ST_ERR:   w_err        = 1'b1;
      default:  w_req_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_inst <= '0;
    end else if (w_accept && w_encodable) begin
      r_inst <= w_go_expand ? pack_inst(w_hi8, bus.req_rd, OP_UPPER)
                            : pack_inst(w_imm8, bus.req_rd, bus.req_op);
`ifdef IMM_ENCODER_EXPAND_EN
    end else if (w_take_first && r_has_pend) begin
      r_inst <= r_pend;
`endif
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.inst_valid = w_inst_valid;
  assign bus.inst       = r_inst;
  assign bus.err        = w_err;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder; expectations follow the macro
// IMM_ENCODER_EXPAND_EN the same way the design does.
module tb_imm_encoder;

  logic clock;
  logic reset;
  int   n_total;
  int   n_bad;

  imm_encoder_if bus_if ();

  imm_encoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [15:0] val);
    chk("req_ready_before_send", {31'd0, bus_if.req_ready}, 32'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = op;
    bus_if.req_rd    = rd;
    bus_if.req_value = val;
    tick();
    bus_if.req_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [15:0] word);
    chk({tag, "_valid"}, {31'd0, bus_if.inst_valid}, 32'd1);
    chk({tag, "_inst"}, {16'd0, bus_if.inst}, {16'd0, word});
    chk({tag, "_err"}, {31'd0, bus_if.err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus_if.req_ready}, 32'd0);
  endtask

  task automatic expect_err(input string tag);
    chk({tag, "_err"}, {31'd0, bus_if.err}, 32'd1);
    chk({tag, "_valid"}, {31'd0, bus_if.inst_valid}, 32'd0);
    tick();
    chk({tag, "_err_gone"}, {31'd0, bus_if.err}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus_if.req_ready}, 32'd1);
  endtask

  // Single-word request with the consumer always ready.
  task automatic single(input string tag, input logic [3:0] op, input logic [3:0] rd,
                        input logic [15:0] val, input logic [15:0] word);
    bus_if.inst_ready = 1'b1;
    send(op, rd, val);
    expect_word(tag, word);
    tick();
    chk({tag, "_one_word"}, {31'd0, bus_if.inst_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus_if.req_ready}, 32'd1);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset             = 1'b0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_op     = 4'd0;
    bus_if.req_rd     = 4'd0;
    bus_if.req_value  = 16'd0;
    bus_if.inst_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd0);
    chk("rst_inst_valid", {31'd0, bus_if.inst_valid}, 32'd0);
    chk("rst_inst", {16'd0, bus_if.inst}, 32'd0);
    chk("rst_err", {31'd0, bus_if.err}, 32'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);

    single("imm0_small", 4'b1000, 4'd3, 16'h0005, 16'h0538);
    single("imm1_neg",   4'b1001, 4'd4, 16'hFF80, 16'h8049);
    single("imm2_max",   4'b1010, 4'd15, 16'h007F, 16'h7FFA);
    single("branch_neg", 4'b0110, 4'd1, 16'hFFFC, 16'hFE16);
    single("upper",      4'b0101, 4'd0, 16'hAB00, 16'hAB05);

    send(4'b0110, 4'd1, 16'h0003); expect_err("branch_odd");
    send(4'b0110, 4'd1, 16'h0200); expect_err("branch_range");
    send(4'b0101, 4'd0, 16'hAB01); expect_err("upper_lowbits");
    send(4'b0011, 4'd2, 16'h0001); expect_err("bad_op");
    send(4'b1011, 4'd2, 16'h0080); expect_err("imm3_range");

    // Expanded request under 3 cycles of backpressure, with a stray request held meanwhile.
    bus_if.inst_ready = 1'b0;
    send(4'b1000, 4'd2, 16'h1280);
`ifdef IMM_ENCODER_EXPAND_EN
    expect_word("exp_first", 16'h1325);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_word($sformatf("exp_hold%0d", i), 16'h1325);
    end
    bus_if.req_valid  = 1'b0;
    bus_if.inst_ready = 1'b1;
    tick();
    expect_word("exp_second", 16'h8028);
    tick();
    chk("exp_done_valid", {31'd0, bus_if.inst_valid}, 32'd0);
    chk("exp_done_idle", {31'd0, bus_if.req_ready}, 32'd1);

    // Reset while the second word is on the bus.
    bus_if.inst_ready = 1'b1;
    send(4'b1000, 4'd2, 16'h1280);
    tick();
    expect_word("rst_e2_second", 16'h8028);
    bus_if.inst_ready = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rst_e2_valid", {31'd0, bus_if.inst_valid}, 32'd0);
    chk("rst_e2_inst", {16'd0, bus_if.inst}, 32'd0);
    bus_if.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_e2_no_pend%0d", i), {31'd0, bus_if.inst_valid}, 32'd0);
    end
`else
    expect_err("exp_off");
    tick();
    chk("exp_off_no_word", {31'd0, bus_if.inst_valid}, 32'd0);
`endif

    // Reset while the first word is stalled.
    bus_if.inst_ready = 1'b0;
    send(4'b0101, 4'd0, 16'hAB00);
    expect_word("rst_e1", 16'hAB05);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rst_e1_valid", {31'd0, bus_if.inst_valid}, 32'd0);
    chk("rst_e1_inst", {16'd0, bus_if.inst}, 32'd0);
    chk("rst_e1_idle", {31'd0, bus_if.req_ready}, 32'd1);

    single("after_reset", 4'b1000, 4'd3, 16'h0005, 16'h0538);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
